// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/note-off events to a fixed pool of
// phase-accumulator voices, with retrigger, free-voice and oldest-voice steal
// priority. Each event passes IDLE -> LOOKUP -> COMMIT (one event per 3 cycles).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ev_valid/ev_ready event handshake (ready only in IDLE)
//   ev_note_on        1 = note-on, 0 = note-off
//   ev_note, ev_step  note number and phase step of the event
//   voice_active      per-voice sounding flag
//   voice_step        per-voice phase step, voice v at [v*STEP_W +: STEP_W]
//   voice_note        per-voice note number, voice v at [v*7 +: 7]
//   voice_phase_rst   one-cycle pulse resetting a voice's phase accumulator
//   steal             one-cycle pulse when a note-on takes over an active voice
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int STEP_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_note_on,
    input  logic [6:0]                   ev_note,
    input  logic [STEP_W-1:0]            ev_step,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*STEP_W-1:0] voice_step,
    output logic [NUM_VOICES*7-1:0]      voice_note,
    output logic [NUM_VOICES-1:0]        voice_phase_rst,
    output logic                         steal
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_COMMIT} state_t;

    state_t state_q, state_d;

    // Latched event
    logic              ev_on_q;
    logic [6:0]        ev_note_q;
    logic [STEP_W-1:0] ev_step_q;

    // Voice state
    logic [NUM_VOICES-1:0] active_q;
    logic [6:0]            note_q [NUM_VOICES];
    logic [STEP_W-1:0]     step_q [NUM_VOICES];
    logic [7:0]            age_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] phase_rst_q;
    logic                  steal_q;

    // Registered lookup result
    logic [IDX_W-1:0] tgt_q, tgt_d;
    logic             tgt_hit_q, tgt_hit_d;     // a voice is to be written
    logic             tgt_steal_q, tgt_steal_d; // write takes over an active voice

    logic accept, lookup, commit;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (ev_valid) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs; ready is gated by reset so it reads 0 while reset is held
    always_comb begin
        ev_ready = (state_q == S_IDLE) && !reset;
        accept   = (state_q == S_IDLE) && ev_valid;
        lookup   = (state_q == S_LOOKUP);
        commit   = (state_q == S_COMMIT);
    end

    // Target selection: retrigger, else first free voice, else oldest active
    // (strict > keeps the lowest index on age ties).
    always_comb begin
        logic             m_found, f_found;
        logic [IDX_W-1:0] m_idx, f_idx, o_idx;
        logic [7:0]       o_age;
        m_found = 1'b0;
        f_found = 1'b0;
        m_idx   = '0;
        f_idx   = '0;
        o_idx   = '0;
        o_age   = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (active_q[v] && note_q[v] == ev_note_q && !m_found) begin
                m_found = 1'b1;
                m_idx   = IDX_W'(v);
            end
            if (!active_q[v] && !f_found) begin
                f_found = 1'b1;
                f_idx   = IDX_W'(v);
            end
            if (v == 0 || age_q[v] > o_age) begin
                o_idx = IDX_W'(v);
                o_age = age_q[v];
            end
        end
        tgt_steal_d = 1'b0;
        if (!ev_on_q) begin
            tgt_hit_d = m_found;
            tgt_d     = m_idx;
        end else if (m_found) begin
            tgt_hit_d = 1'b1;
            tgt_d     = m_idx;
        end else if (f_found) begin
            tgt_hit_d = 1'b1;
            tgt_d     = f_idx;
        end else begin
            tgt_hit_d   = 1'b1;
            tgt_d       = o_idx;
            tgt_steal_d = 1'b1;
        end
    end

    // Event latch and lookup register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            ev_step_q   <= '0;
            tgt_q       <= '0;
            tgt_hit_q   <= 1'b0;
            tgt_steal_q <= 1'b0;
        end else begin
            if (accept) begin
                ev_on_q   <= ev_note_on;
                ev_note_q <= ev_note;
                ev_step_q <= ev_step;
            end
            if (lookup) begin
                tgt_q       <= tgt_d;
                tgt_hit_q   <= tgt_hit_d;
                tgt_steal_q <= tgt_steal_d;
            end
        end
    end

    // Voice arrays, written on the closing edge of COMMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q    <= '0;
            phase_rst_q <= '0;
            steal_q     <= 1'b0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                step_q[v] <= '0;
                age_q[v]  <= '0;
            end
        end else begin
            phase_rst_q <= '0;
            steal_q     <= 1'b0;
            if (commit && tgt_hit_q) begin
                if (ev_on_q) begin
                    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == tgt_q) begin
                            active_q[v] <= 1'b1;
                            note_q[v]   <= ev_note_q;
                            step_q[v]   <= ev_step_q;
                            age_q[v]    <= '0;
                        end else if (active_q[v] && age_q[v] != 8'hFF) begin
                            age_q[v] <= age_q[v] + 8'd1;
                        end
                    end
                    phase_rst_q[tgt_q] <= 1'b1;
                    steal_q            <= tgt_steal_q;
                end else begin
                    active_q[tgt_q] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        voice_step = '0;
        voice_note = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            voice_step[v*STEP_W +: STEP_W] = step_q[v];
            voice_note[v*7 +: 7]           = note_q[v];
        end
    end

    assign voice_active    = active_q;
    assign voice_phase_rst = phase_rst_q;
    assign steal           = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    logic         clk = 1'b0;
    logic         reset;
    logic         ev_valid;
    logic         ev_ready;
    logic         ev_note_on;
    logic [6:0]   ev_note;
    logic [31:0]  ev_step;
    logic [3:0]   voice_active;
    logic [127:0] voice_step;
    logic [27:0]  voice_note;
    logic [3:0]   voice_phase_rst;
    logic         steal;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [3:0]   exp_active;
    logic [127:0] exp_step;
    logic [27:0]  exp_note;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(4), .STEP_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_note_on     (ev_note_on),
        .ev_note        (ev_note),
        .ev_step        (ev_step),
        .voice_active   (voice_active),
        .voice_step     (voice_step),
        .voice_note     (voice_note),
        .voice_phase_rst(voice_phase_rst),
        .steal          (steal)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_v(input int v, input logic [6:0] n, input logic [31:0] s);
        exp_active[v]        = 1'b1;
        exp_note[v*7 +: 7]   = n;
        exp_step[v*32 +: 32] = s;
    endtask

    task automatic chk_voices(input string tag);
        chk({tag, "_active"}, {124'd0, voice_active}, {124'd0, exp_active});
        chk({tag, "_note"},   {100'd0, voice_note},   {100'd0, exp_note});
        chk({tag, "_step"},   voice_step,             exp_step);
    endtask

    // Runs one event through the handshake, starting at a negedge. With poke
    // set, a second request is presented while the allocator is busy.
    task automatic do_event(input string tag, input logic on, input logic [6:0] note,
                            input logic [31:0] step, input logic [3:0] exp_rst,
                            input logic exp_steal, input logic poke);
        chk({tag, "_ready_idle"}, {127'd0, ev_ready}, 128'd1);
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_note    = note;
        ev_step    = step;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        if (poke) begin
            ev_valid   = 1'b1;
            ev_note_on = 1'b1;
            ev_note    = 7'd10;
            ev_step    = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        chk({tag, "_ready_lookup"}, {127'd0, ev_ready}, 128'd0);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_commit"}, {127'd0, ev_ready}, 128'd0);
        chk({tag, "_rst_early"}, {124'd0, voice_phase_rst}, 128'd0);
        @(negedge clk);
        chk({tag, "_ready_back"}, {127'd0, ev_ready}, 128'd1);
        chk({tag, "_phase_rst"}, {124'd0, voice_phase_rst}, {124'd0, exp_rst});
        chk({tag, "_steal"}, {127'd0, steal}, {127'd0, exp_steal});
        @(negedge clk);
        chk({tag, "_rst_clear"}, {124'd0, voice_phase_rst}, 128'd0);
        chk({tag, "_steal_clear"}, {127'd0, steal}, 128'd0);
    endtask

    initial begin
        reset      = 1'b1;
        ev_valid   = 1'b0;
        ev_note_on = 1'b0;
        ev_note    = '0;
        ev_step    = '0;
        exp_active = '0;
        exp_step   = '0;
        exp_note   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ready", {127'd0, ev_ready}, 128'd0);
        chk("reset_phase_rst", {124'd0, voice_phase_rst}, 128'd0);
        chk("reset_steal", {127'd0, steal}, 128'd0);
        chk_voices("reset");
        reset = 1'b0;
        #1;
        chk("post_reset_ready", {127'd0, ev_ready}, 128'd1);
        @(negedge clk);

        // Fill all four voices
        do_event("on60", 1'b1, 7'd60, 32'h0100_0000, 4'b0001, 1'b0, 1'b0);
        set_v(0, 7'd60, 32'h0100_0000);
        chk_voices("on60");
        do_event("on62", 1'b1, 7'd62, 32'h0110_0000, 4'b0010, 1'b0, 1'b0);
        set_v(1, 7'd62, 32'h0110_0000);
        do_event("on64", 1'b1, 7'd64, 32'h0120_0000, 4'b0100, 1'b0, 1'b0);
        set_v(2, 7'd64, 32'h0120_0000);
        do_event("on67", 1'b1, 7'd67, 32'h0130_0000, 4'b1000, 1'b0, 1'b0);
        set_v(3, 7'd67, 32'h0130_0000);
        chk_voices("full");

        // All busy: voice 0 is oldest and gets stolen
        do_event("on72", 1'b1, 7'd72, 32'h0140_0000, 4'b0001, 1'b1, 1'b0);
        set_v(0, 7'd72, 32'h0140_0000);
        chk_voices("steal72");

        // Retrigger of voice 1 with a new step
        do_event("re62", 1'b1, 7'd62, 32'h0200_0000, 4'b0010, 1'b0, 1'b0);
        set_v(1, 7'd62, 32'h0200_0000);
        chk_voices("re62");

        // Note-off frees voice 2 but keeps its note/step
        do_event("off64", 1'b0, 7'd64, 32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b0);
        exp_active[2] = 1'b0;
        chk_voices("off64");

        // Free voice 2 wins over stealing
        do_event("on50", 1'b1, 7'd50, 32'h0150_0000, 4'b0100, 1'b0, 1'b0);
        set_v(2, 7'd50, 32'h0150_0000);
        chk_voices("on50");

        // Note-off with no holder changes nothing
        do_event("off99", 1'b0, 7'd99, 32'h0, 4'b0000, 1'b0, 1'b0);
        chk_voices("off99");

        // Ages now v0=2 v1=1 v2=0 v3=3: voice 3 stolen; request while busy ignored
        do_event("on80", 1'b1, 7'd80, 32'h0160_0000, 4'b1000, 1'b1, 1'b1);
        set_v(3, 7'd80, 32'h0160_0000);
        @(negedge clk);
        chk("poke_ignored_ready", {127'd0, ev_ready}, 128'd1);
        chk_voices("on80");

        // Zero step is a legal note-on
        do_event("off62", 1'b0, 7'd62, 32'h0, 4'b0000, 1'b0, 1'b0);
        exp_active[1] = 1'b0;
        do_event("on5", 1'b1, 7'd5, 32'h0, 4'b0010, 1'b0, 1'b0);
        set_v(1, 7'd5, 32'h0);
        chk_voices("on5_zero_step");

        // Reset asserted during COMMIT of a note-on abandons it
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_note    = 7'd70;
        ev_step    = 32'h0170_0000;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_active = '0;
        exp_note   = '0;
        exp_step   = '0;
        @(negedge clk);
        chk("rstc_ready", {127'd0, ev_ready}, 128'd0);
        chk_voices("rstc");
        @(negedge clk);
        chk("rstc_phase_rst", {124'd0, voice_phase_rst}, 128'd0);
        chk("rstc_steal", {127'd0, steal}, 128'd0);
        reset = 1'b0;
        #1;
        chk("rstc_ready_after", {127'd0, ev_ready}, 128'd1);
        chk_voices("rstc_after");
        @(negedge clk);

        // Allocation restarts from voice 0
        do_event("on33", 1'b1, 7'd33, 32'h0180_0000, 4'b0001, 1'b0, 1'b0);
        set_v(0, 7'd33, 32'h0180_0000);
        chk_voices("on33");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
